// File: rtl/timer_pkg.sv
// Shared types and default widths for the timer controller slice.
package timer_pkg;

  localparam int TIMER_CNT_W = 8;
  localparam int TIMER_PRE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick_o every div_i+1 cycles; load_i parks the count at 0.
module tick_prescaler #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (load_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: drives enable/clear of an external up-counter and flags compare match.
// Prescaler is built only when TIMER_CTRL_PRESCALE_EN is defined; otherwise every RUN cycle ticks.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int COUNTER_WIDTH  = TIMER_CNT_W,
  parameter int PRESCALE_WIDTH = TIMER_PRE_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      periodic_i,
  input  logic [COUNTER_WIDTH-1:0]  cmp_val_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic [COUNTER_WIDTH-1:0]  count_i,
  output logic                      cnt_en_o,
  output logic                      cnt_clr_o,
  output logic                      busy_o,
  output logic                      match_o,
  output logic                      done_o
);

  timer_state_e state_q, state_d;

  logic [COUNTER_WIDTH-1:0] cmp_q;
  logic                     periodic_q;
  logic                     start_ok;
  logic                     tick;
  logic                     hit;

  // stop_i outranks start_i, so a simultaneous pair never launches a run
  assign start_ok = start_i && !stop_i && ((state_q == IDLE) || (state_q == DONE));
  assign hit      = (count_i == cmp_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_q      <= '0;
      periodic_q <= 1'b0;
    end else if (start_ok) begin
      cmp_q      <= cmp_val_i;
      periodic_q <= periodic_i;
    end
  end

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      pre_tick;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale_q <= '0;
    end else if (start_ok) begin
      prescale_q <= prescale_i;
    end
  end

  // Held at 0 outside RUN so the first RUN cycle starts a fresh tick period
  tick_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (state_q != RUN),
    .div_i  (prescale_q),
    .tick_o (pre_tick)
  );

  assign tick = (state_q == RUN) && pre_tick;
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale_i;
  assign tick            = (state_q == RUN);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = stop_i ? IDLE : RUN;
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (tick && hit && !periodic_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (start_ok) begin
          state_d = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_en_o  = 1'b0;
    cnt_clr_o = 1'b0;
    match_o   = 1'b0;
    if (!stop_i) begin
      case (state_q)
        CLEAR: begin
          cnt_en_o  = 1'b1;
          cnt_clr_o = 1'b1;
        end
        RUN: begin
          if (tick) begin
            if (hit) begin
              // periodic wraps via clear; one-shot freezes the counter at cmp_q
              match_o   = 1'b1;
              cnt_en_o  = periodic_q;
              cnt_clr_o = periodic_q;
            end else begin
              cnt_en_o  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q == CLEAR) || (state_q == RUN);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with a behavioural model of the controlled up-counter.
`timescale 1ns/1ps
module tb_timer_ctrl;

  localparam int CW = 8;
  localparam int PW = 4;

  logic          clk_i      = 1'b0;
  logic          rst_ni     = 1'b0;
  logic          start_i    = 1'b0;
  logic          stop_i     = 1'b0;
  logic          periodic_i = 1'b0;
  logic [CW-1:0] cmp_val_i  = '0;
  logic [PW-1:0] prescale_i = '0;
  logic [CW-1:0] count_i    = '0;
  logic          cnt_en_o, cnt_clr_o, busy_o, match_o, done_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  timer_ctrl #(
    .COUNTER_WIDTH  (CW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .periodic_i (periodic_i),
    .cmp_val_i  (cmp_val_i),
    .prescale_i (prescale_i),
    .count_i    (count_i),
    .cnt_en_o   (cnt_en_o),
    .cnt_clr_o  (cnt_clr_o),
    .busy_o     (busy_o),
    .match_o    (match_o),
    .done_o     (done_o)
  );

  // The generic up-counter the controller drives
  always @(posedge clk_i) begin
    if (cnt_en_o) count_i <= cnt_clr_o ? '0 : count_i + 8'd1;
  end

  typedef struct {
    logic       per;
    logic [7:0] cmp;
    logic [3:0] pre;
    int         first;   // cycle offset of first match after start cycle T
    int         period;  // cycles between matches
    int         ncyc;
  } vec_t;

  typedef struct {
    int         k;
    logic [2:0] exp;     // {busy, done, match}
  } sb_t;

  vec_t vt[7];
  sb_t  sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic start_pulse(input logic per, input logic [7:0] cmp, input logic [3:0] pre);
    @(negedge clk_i);
    periodic_i = per;
    cmp_val_i  = cmp;
    prescale_i = pre;
    start_i    = 1'b1;
  endtask

  task automatic go_idle(input string name);
    @(negedge clk_i);
    start_i = 1'b0;
    stop_i  = 1'b1;
    @(negedge clk_i);
    stop_i  = 1'b0;
    check({name, " idle"}, {30'd0, busy_o, done_o}, 32'd0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    sb_t  s;
    logic m;
    v = vt[idx];
    start_pulse(v.per, v.cmp, v.pre);
    for (int k = 1; k <= v.ncyc; k++) begin
      m = (k >= v.first) && (v.per ? (((k - v.first) % v.period) == 0) : (k == v.first));
      s.k   = k;
      s.exp = {(v.per || k <= v.first), (!v.per && k > v.first), m};
      sbq.push_back(s);
    end
    for (int k = 1; k <= v.ncyc; k++) begin
      @(negedge clk_i);
      // Mid-run start requests and input churn must be ignored
      start_i    = (k >= 2 && k < v.first) ? 1'($urandom % 2) : 1'b0;
      cmp_val_i  = 8'($urandom);
      prescale_i = 4'($urandom);
      periodic_i = 1'($urandom % 2);
      #1;
      if (sbq.size() == 0) begin
        check($sformatf("vec%0d scoreboard empty", idx), 32'd0, 32'd1);
      end else begin
        s = sbq.pop_front();
        check($sformatf("vec%0d k%0d busy/done/match", idx, s.k),
              {29'd0, busy_o, done_o, match_o}, {29'd0, s.exp});
      end
      if (k == 2) check($sformatf("vec%0d first RUN count", idx), {24'd0, count_i}, 32'd0);
      if (!v.per && k == v.first + 2)
        check($sformatf("vec%0d hold count", idx), {24'd0, count_i}, {24'd0, v.cmp});
    end
    go_idle($sformatf("vec%0d", idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{1'b0, 8'd3,   4'd0, 5,   4,   0};
    vt[1] = '{1'b1, 8'd3,   4'd0, 5,   4,   0};
    vt[3] = '{1'b0, 8'd0,   4'd0, 2,   1,   0};
    vt[4] = '{1'b0, 8'd255, 4'd0, 257, 256, 0};
`ifdef TIMER_CTRL_PRESCALE_EN
    vt[2] = '{1'b1, 8'd1,   4'd2, 7,   6,   0};
    vt[5] = '{1'b1, 8'd0,   4'd3, 5,   4,   0};
    vt[6] = '{1'b1, 8'd2,   4'd1, 7,   6,   0};
`else
    vt[2] = '{1'b1, 8'd1,   4'd2, 3,   2,   0};
    vt[5] = '{1'b1, 8'd0,   4'd3, 2,   1,   0};
    vt[6] = '{1'b1, 8'd2,   4'd1, 4,   3,   0};
`endif
    foreach (vt[i]) vt[i].ncyc = vt[i].per ? vt[i].first + 2 * vt[i].period + 1 : vt[i].first + 3;

    // Reset state
    #1;
    check("reset outputs", {27'd0, cnt_en_o, cnt_clr_o, busy_o, match_o, done_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("idle no enable", {30'd0, cnt_en_o, busy_o}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // stop_i at T+4 of one-shot cmp=3
    start_pulse(1'b0, 8'd3, 4'd0);
    @(negedge clk_i); start_i = 1'b0; #1;
    check("stop T+1 en/clr", {30'd0, cnt_en_o, cnt_clr_o}, 32'd3);
    @(negedge clk_i); #1;
    check("stop T+2 count", {24'd0, count_i}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i); stop_i = 1'b1; #1;
    check("stop T+4 en/match", {30'd0, cnt_en_o, match_o}, 32'd0);
    @(negedge clk_i); stop_i = 1'b0; #1;
    check("stop T+5 busy/done", {30'd0, busy_o, done_o}, 32'd0);
    check("stop T+5 count", {24'd0, count_i}, 32'd2);
    @(negedge clk_i);
    @(negedge clk_i); #1;
    check("stop count holds", {24'd0, count_i}, 32'd2);

    // cmp=0 one-shot then restart from DONE
    start_pulse(1'b0, 8'd0, 4'd0);
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i); #1;
    check("cmp0 T+2 match", {31'd0, match_o}, 32'd1);
    @(negedge clk_i); #1;
    check("cmp0 T+3 done", {31'd0, done_o}, 32'd1);
    @(negedge clk_i); start_i = 1'b1; cmp_val_i = 8'd5; #1;
    check("cmp0 T+4 still done", {31'd0, done_o}, 32'd1);
    @(negedge clk_i); start_i = 1'b0; #1;
    check("restart T+5 clear", {29'd0, cnt_en_o, cnt_clr_o, busy_o}, 32'd7);
    @(negedge clk_i); #1;
    check("restart T+6 count", {24'd0, count_i}, 32'd0);
    go_idle("restart");

    // Asynchronous reset mid-RUN
    start_pulse(1'b1, 8'd3, 4'd0);
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i); #1;
    check("pre-reset busy", {31'd0, busy_o}, 32'd1);
    #1 rst_ni = 1'b0; #1;
    check("async reset outputs", {27'd0, cnt_en_o, cnt_clr_o, busy_o, match_o, done_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i); #1;
      check($sformatf("post-reset idle %0d", k), {30'd0, cnt_en_o, busy_o}, 32'd0);
    end
    start_pulse(1'b0, 8'd2, 4'd0);
    @(negedge clk_i); start_i = 1'b0; #1;
    check("post-reset start clear", {30'd0, cnt_en_o, cnt_clr_o}, 32'd3);
    go_idle("post-reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
